// File: rtl/multi_random_pulse_gen.sv
// Multi-channel burst pulse generator with LFSR-randomised spacing between bursts.
// Each channel runs its own IDLE/PULSE/GAP/WAIT machine on a config snapshot taken at burst start.
module multi_random_pulse_gen #(
    parameter int unsigned g_num_channels = 4,
    parameter int unsigned g_cnt_width    = 16,
    parameter logic [31:0] g_seed         = 32'h1
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_n_i,
    input  logic [g_num_channels-1:0] enable_i,
    input  logic [g_cnt_width-1:0]    pulse_width_i,
    input  logic [g_cnt_width-1:0]    min_spacing_i,
    input  logic [4:0]                rand_range_log2_i,
    input  logic [7:0]                repetition_i,
    input  logic [g_cnt_width-1:0]    burst_spacing_i,
    output logic [g_num_channels-1:0] pulse_o,
    output logic [g_num_channels-1:0] burst_done_p1_o,
    output logic [g_num_channels-1:0] busy_o
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StWait} state_e;

    localparam logic [31:0]            LfsrTaps = 32'h80200003;
    localparam logic [g_cnt_width-1:0] One      = g_cnt_width'(1);

    function automatic logic [31:0] seed_for(int unsigned idx);
        logic [31:0] s;
        s = g_seed ^ (idx * 32'h9E3779B9);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    for (genvar c = 0; c < g_num_channels; c++) begin : g_chan
        localparam logic [31:0] Seed = seed_for(c);

        state_e                 state_q, state_d;
        logic [g_cnt_width-1:0] cnt_q, cnt_d;
        logic [g_cnt_width-1:0] width_q, width_d;
        logic [g_cnt_width-1:0] gap_q, gap_d;
        logic [g_cnt_width-1:0] min_q, min_d;
        logic [4:0]             k_q, k_d;
        logic [7:0]             rep_q, rep_d;
        logic [31:0]            lfsr_q, lfsr_d;
        logic                   pulse_q, pulse_d;
        logic                   done_q, done_d;
        logic [g_cnt_width-1:0] rand_mask, wait_len;
        logic [g_cnt_width:0]   wait_sum;
        logic                   start;

        always_comb begin
            rand_mask = '1;
            if (32'(k_q) < g_cnt_width) begin
                rand_mask = (One << k_q) - One;
            end
            wait_sum = {1'b0, min_q} + {1'b0, lfsr_q[g_cnt_width-1:0] & rand_mask};
            wait_len = wait_sum[g_cnt_width] ? '1 : wait_sum[g_cnt_width-1:0];
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            width_d = width_q;
            gap_d   = gap_q;
            min_d   = min_q;
            k_d     = k_q;
            rep_d   = rep_q;
            pulse_d = 1'b0;
            done_d  = 1'b0;
            start   = 1'b0;
            lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);

            // Counters hold (length - 1); zero-length settings collapse to one cycle.
            unique case (state_q)
                StIdle: begin
                    start = enable_i[c];
                end
                StPulse: begin
                    if (cnt_q != '0) begin
                        cnt_d   = cnt_q - One;
                        pulse_d = 1'b1;
                    end else if (rep_q > 8'd1) begin
                        rep_d   = rep_q - 8'd1;
                        state_d = StGap;
                        cnt_d   = (gap_q == '0) ? '0 : gap_q - One;
                    end else begin
                        state_d = StWait;
                        done_d  = 1'b1;
                        cnt_d   = (wait_len == '0) ? '0 : wait_len - One;
                    end
                end
                StGap: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - One;
                    end else begin
                        state_d = StPulse;
                        pulse_d = 1'b1;
                        cnt_d   = (width_q == '0) ? '0 : width_q - One;
                    end
                end
                StWait: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - One;
                    end else if (enable_i[c]) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (start) begin
                width_d = pulse_width_i;
                gap_d   = burst_spacing_i;
                min_d   = min_spacing_i;
                k_d     = rand_range_log2_i;
                rep_d   = (repetition_i == 8'd0) ? 8'd1 : repetition_i;
                cnt_d   = (pulse_width_i == '0) ? '0 : pulse_width_i - One;
                state_d = StPulse;
                pulse_d = 1'b1;
            end

            // Losing enable aborts silently from any state.
            if (!enable_i[c]) begin
                state_d = StIdle;
                cnt_d   = '0;
                pulse_d = 1'b0;
                done_d  = 1'b0;
            end
        end

        always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                width_q <= '0;
                gap_q   <= '0;
                min_q   <= '0;
                k_q     <= '0;
                rep_q   <= '0;
                lfsr_q  <= Seed;
                pulse_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                width_q <= width_d;
                gap_q   <= gap_d;
                min_q   <= min_d;
                k_q     <= k_d;
                rep_q   <= rep_d;
                lfsr_q  <= lfsr_d;
                pulse_q <= pulse_d;
                done_q  <= done_d;
            end
        end

        assign pulse_o[c]         = pulse_q;
        assign burst_done_p1_o[c] = done_q;
        assign busy_o[c]          = (state_q != StIdle);
    end

endmodule

// File: tb/tb_multi_random_pulse_gen.sv
// Directed bench for multi_random_pulse_gen: expected high/low run lengths are queued
// as stimulus is applied and checked by a run-length monitor on the selected channel.
module tb_multi_random_pulse_gen;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] enable;
    logic [CW-1:0]  pulse_width, min_spacing, burst_spacing;
    logic [4:0]     rand_k;
    logic [7:0]     repetition;
    logic [NCH-1:0] pulse, done, busy;

    multi_random_pulse_gen #(
        .g_num_channels(NCH),
        .g_cnt_width   (CW),
        .g_seed        (32'h1)
    ) dut (
        .clk_sys_i        (clk),
        .rst_n_i          (rst_n),
        .enable_i         (enable),
        .pulse_width_i    (pulse_width),
        .min_spacing_i    (min_spacing),
        .rand_range_log2_i(rand_k),
        .repetition_i     (repetition),
        .burst_spacing_i  (burst_spacing),
        .pulse_o          (pulse),
        .burst_done_p1_o  (done),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit lvl;
        int len;
        bit rnd;
    } seg_t;

    int   checks = 0;
    int   errors = 0;
    seg_t exp_q[$];
    int   rec_q[$];
    int   seq_a[$];
    int   hist[32];

    function automatic logic [31:0] seed_of(int c);
        logic [31:0] s;
        s = 32'h1 ^ (32'(c) * 32'h9E3779B9);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
    endfunction

    // Expected WAIT length from the LFSR value seen on WAIT entry.
    function automatic int rand_wait(logic [31:0] l);
        int mask;
        int w;
        mask = (int'(rand_k) >= CW) ? 32'hffff : ((1 << rand_k) - 1);
        w = int'(min_spacing) + (int'(l[15:0]) & mask);
        if (w > 65535) w = 65535;
        if (w < 1) w = 1;
        return w;
    endfunction

    logic [31:0] m_lfsr[NCH];
    logic [31:0] m_prev[NCH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_lfsr[c] <= seed_of(c);
                m_prev[c] <= seed_of(c);
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                m_prev[c] <= m_lfsr[c];
                m_lfsr[c] <= lfsr_step(m_lfsr[c]);
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Run-length monitor.
    bit          mon_en = 0;
    int          mon_ch = 0;
    bit          armed;
    logic        cur_lvl;
    int          run;
    logic        prev_p;
    logic        mp;
    logic [31:0] wait_lfsr;
    int          done_cnt;
    bit          rec = 0;
    seg_t        me;
    int          want;

    always @(negedge clk) begin
        if (mon_en) begin
            mp = pulse[mon_ch];
            if (done[mon_ch] === 1'b1) begin
                done_cnt++;
                checks++;
                assert (prev_p === 1'b1 && mp === 1'b0) else begin
                    errors++;
                    $error("FAIL done_align observed pulse %b->%b expected 1->0", prev_p, mp);
                end
            end
            if (!armed) begin
                if (mp === 1'b1) begin
                    armed   = 1;
                    cur_lvl = 1'b1;
                    run     = 1;
                end
            end else if (mp === cur_lvl) begin
                run++;
            end else begin
                if (cur_lvl === 1'b1) wait_lfsr = m_prev[mon_ch];
                if (exp_q.size() > 0) begin
                    me   = exp_q.pop_front();
                    want = me.rnd ? rand_wait(wait_lfsr) : me.len;
                    checks++;
                    assert (cur_lvl === me.lvl && run == want) else begin
                        errors++;
                        $error("FAIL run observed lvl %b len %0d expected lvl %b len %0d",
                               cur_lvl, run, me.lvl, want);
                    end
                    if (me.rnd) begin
                        if (run >= 0 && run < 32) hist[run]++;
                        if (rec) rec_q.push_back(run);
                    end
                end
                cur_lvl = mp;
                run     = 1;
            end
            prev_p = mp;
        end
    end

    task automatic push(bit lvl, int len, bit rnd);
        seg_t s;
        s.lvl = lvl;
        s.len = len;
        s.rnd = rnd;
        exp_q.push_back(s);
    endtask

    task automatic cfg(int w, int r, int bs, int mn, int k);
        pulse_width   = 16'(w);
        repetition    = 8'(r);
        burst_spacing = 16'(bs);
        min_spacing   = 16'(mn);
        rand_k        = 5'(k);
    endtask

    task automatic start_mon(int ch);
        mon_ch   = ch;
        armed    = 0;
        prev_p   = 1'b0;
        done_cnt = 0;
        mon_en   = 1;
    endtask

    task automatic stop_all();
        enable = '0;
        mon_en = 0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic wait_q(string tag, int limit);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_high(int ch, string tag);
        int n;
        n = 0;
        while (pulse[ch] !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, pulse[ch], 1);
    endtask

    task automatic run_rand(int n, string tag);
        enable = '0;
        mon_en = 0;
        rst_n  = 1'b0;
        cfg(1, 1, 0, 8, 4);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        exp_q.delete();
        push(1, 1, 0);
        for (int i = 0; i < n; i++) begin
            push(0, 0, 1);
            push(1, 1, 0);
        end
        rec_q.delete();
        for (int v = 0; v < 32; v++) hist[v] = 0;
        rec = 1;
        start_mon(0);
        enable = 4'b0001;
        wait_q(tag, n * 40 + 100);
        rec = 0;
        check({tag, "_count"}, rec_q.size(), n);
        stop_all();
    endtask

    int          rises;
    logic        prevp;
    logic        seen;
    int          nwait;
    int          mism;
    int          exp_w[NCH];
    int          lowcnt[NCH];
    bit          risen[NCH];

    initial begin
        rst_n  = 1'b0;
        enable = '0;
        cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_pulse", pulse, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("no_start_without_enable", busy, 0);

        // width 3, single pulse bursts, 10 low cycles
        cfg(3, 1, 0, 10, 0);
        push(1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            push(0, 10, 0);
            push(1, 3, 0);
        end
        start_mon(0);
        enable = 4'b0001;
        wait_q("period13", 200);
        check("period13_done", done_cnt, 4);
        stop_all();
        check("period13_idle", busy, 0);

        // 3-pulse bursts with 4-cycle spacing, 20 low between bursts
        cfg(2, 3, 4, 20, 0);
        for (int b = 0; b < 2; b++) begin
            push(1, 2, 0); push(0, 4, 0);
            push(1, 2, 0); push(0, 4, 0);
            push(1, 2, 0);
            if (b == 0) push(0, 20, 0);
        end
        start_mon(0);
        enable = 4'b0001;
        wait_q("burst3", 300);
        check("burst3_done", done_cnt, 2);
        stop_all();

        // abort during second pulse of a burst
        cfg(4, 3, 2, 5, 0);
        rises  = 0;
        prevp  = 1'b0;
        nwait  = 0;
        enable = 4'b0001;
        while (rises < 2 && nwait < 200) begin
            @(negedge clk);
            #1;
            nwait++;
            if (pulse[0] && !prevp) rises++;
            prevp = pulse[0];
        end
        check("abort_reached", rises, 2);
        enable = '0;
        @(negedge clk);
        #1;
        check("abort_pulse", pulse[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #1;
            seen = seen | done[0] | pulse[0];
        end
        check("abort_quiet", seen, 0);
        stop_all();

        // zero width/repetition/spacing fold to one
        cfg(0, 0, 0, 3, 0);
        push(1, 1, 0); push(0, 3, 0); push(1, 1, 0); push(0, 3, 0); push(1, 1, 0);
        start_mon(0);
        enable = 4'b0001;
        wait_q("zero_cfg", 100);
        check("zero_cfg_done", done_cnt, 3);
        stop_all();

        // zero burst spacing inside a burst still leaves one low cycle
        cfg(1, 2, 0, 3, 0);
        push(1, 1, 0); push(0, 1, 0); push(1, 1, 0); push(0, 3, 0);
        push(1, 1, 0); push(0, 1, 0); push(1, 1, 0);
        start_mon(0);
        enable = 4'b0001;
        wait_q("zero_gap", 100);
        stop_all();

        // width change mid-burst applies from the next burst
        cfg(2, 3, 2, 4, 0);
        push(1, 2, 0); push(0, 2, 0); push(1, 2, 0); push(0, 2, 0); push(1, 2, 0);
        push(0, 4, 0);
        push(1, 5, 0); push(0, 2, 0); push(1, 5, 0); push(0, 2, 0); push(1, 5, 0);
        start_mon(0);
        enable = 4'b0001;
        wait_high(0, "shadow_first_pulse");
        pulse_width = 16'd5;
        wait_q("shadow_cfg", 200);
        stop_all();

        // reset asserted mid-pulse drops outputs without a clock edge
        cfg(10, 1, 0, 5, 0);
        enable = 4'b0001;
        wait_high(0, "async_rst_pulse_up");
        rst_n = 1'b0;
        #1;
        check("async_rst_pulse", pulse, 0);
        check("async_rst_busy", busy, 0);
        enable = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // all channels together, identical config, k=6
        cfg(2, 1, 0, 5, 6);
        enable = 4'b1111;
        @(negedge clk);
        #1;
        check("multi_start_pulse", pulse, 4'hf);
        check("multi_start_busy", busy, 4'hf);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("multi_fall", pulse, 0);
        check("multi_done", done, 4'hf);
        for (int c = 0; c < NCH; c++) begin
            exp_w[c]  = rand_wait(m_prev[c]);
            lowcnt[c] = 1;
            risen[c]  = 0;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (!risen[c]) begin
                    if (pulse[c]) risen[c] = 1;
                    else lowcnt[c]++;
                end
            end
        end
        for (int c = 0; c < NCH; c++) check($sformatf("multi_wait_ch%0d", c), lowcnt[c], exp_w[c]);
        stop_all();

        // random spacing: min 8, k 4, every value of [8,23] reached, repeatable after reset
        run_rand(1000, "rand_a");
        for (int v = 8; v <= 23; v++) check($sformatf("rand_hit_%0d", v), (hist[v] > 0), 1);
        seq_a = rec_q;
        run_rand(200, "rand_b");
        mism = 0;
        for (int i = 0; i < 200; i++) begin
            if (i < rec_q.size() && i < seq_a.size()) begin
                if (rec_q[i] != seq_a[i]) mism++;
            end else begin
                mism++;
            end
        end
        check("rand_repeatable", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_random_pulse_gen.md
MULTI_RANDOM_PULSE_GEN -- requirements
Module: multi_random_pulse_gen

Interface
REQ-001 SHALL have parameter g_num_channels, default 4, meaning number of independent pulse channels (1..16).
REQ-002 SHALL have parameter g_cnt_width, default 16, meaning width of all timing counters and configuration fields, in clock cycles.
REQ-003 SHALL have parameter g_seed, default 32'h1, meaning base 32-bit LFSR seed.
REQ-004 SHALL have port clk_sys_i  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_i  in  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port enable_i  in  g_num_channels  per-channel run enable.
REQ-007 SHALL have port pulse_width_i  in  g_cnt_width  pulse high time, cycles.
REQ-008 SHALL have port min_spacing_i  in  g_cnt_width  minimum low time between bursts, cycles.
REQ-009 SHALL have port rand_range_log2_i  in  5  random spacing range exponent k.
REQ-010 SHALL have port repetition_i  in  8  pulses per burst.
REQ-011 SHALL have port burst_spacing_i  in  g_cnt_width  low time between pulses inside a burst, cycles.
REQ-012 SHALL have port pulse_o  out  g_num_channels  generated pulses, registered.
REQ-013 SHALL have port burst_done_p1_o  out  g_num_channels  one-cycle strobe at end of each burst's last pulse.
REQ-014 SHALL have port busy_o  out  g_num_channels  channel FSM not IDLE.

Function
REQ-015 SHALL give each channel an independent FSM with states IDLE, PULSE, GAP, WAIT.
REQ-016 SHALL give each channel a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seeded with g_seed XOR (channel index * 32'h9E3779B9); an all-zero seed SHALL be replaced by 32'h1.
REQ-017 SHALL advance every LFSR each clock regardless of enable.
REQ-018 SHALL, in IDLE with enable_i high, latch all configuration inputs into a per-channel shadow and enter PULSE on the next edge; configuration changes SHALL NOT affect a burst in progress.
REQ-019 SHALL drive pulse_o high for exactly max(pulse_width,1) cycles per pulse, starting the cycle after PULSE entry is registered.
REQ-020 SHALL treat repetition_i = 0 as 1.
REQ-021 SHALL, after each non-final pulse, go PULSE->GAP for burst_spacing cycles (0 = direct PULSE->PULSE with one low cycle minimum), then GAP->PULSE.
REQ-022 SHALL, after the final pulse, pulse burst_done_p1_o for one cycle and enter WAIT.
REQ-023 SHALL compute WAIT length = min_spacing + (LFSR[g_cnt_width-1:0] AND (2^k - 1)), with k clamped to g_cnt_width, saturating at 2^g_cnt_width - 1, sampled on WAIT entry.
REQ-024 SHALL, at WAIT expiry, return to IDLE; if enable_i is still high the next burst SHALL start without an extra idle cycle.
REQ-025 SHALL, when enable_i falls in any state, force pulse_o low on the next edge, abort the burst without burst_done_p1_o, and enter IDLE.
REQ-026 SHALL keep pulse_o low for at least one cycle between any two pulses.
REQ-027 SHALL keep channels fully independent; simultaneous events on several channels SHALL be handled in the same cycle.

Reset
REQ-028 SHALL, while rst_n_i is low, hold all FSMs in IDLE, pulse_o, burst_done_p1_o and busy_o at 0, counters at 0, and LFSRs at their seeds.
REQ-029 SHALL, on reset assertion mid-pulse, drop pulse_o asynchronously.
REQ-030 SHALL, after reset release, not start a burst before the first edge where enable_i is sampled high.

Verification
REQ-031 SHALL cover: width=3, rep=1, min=10, k=0, enable ch0 -> 3-cycle pulses, exactly 10 low cycles between them (13-cycle period).
REQ-032 SHALL cover: width=2, rep=3, burst_spacing=4, min=20, k=0 -> three 2-cycle pulses 4 apart, burst_done_p1_o one cycle after third pulse end, then 20 low.
REQ-033 SHALL cover: min=8, k=4, 1000 bursts -> all gaps in [8,23], every value hit, same sequence after reset.
REQ-034 SHALL cover: enable_i drops during second pulse of rep=3 -> pulse_o low next cycle, no burst_done_p1_o, busy_o 0.
REQ-035 SHALL cover: width=0, rep=0, burst_spacing=0 -> single 1-cycle pulses; width changed mid-burst -> applies from next burst only.
REQ-036 SHALL cover: all 4 channels enabled same cycle, identical config, k=6 -> channels start together, then diverge per their LFSR sequences.
